display_capture_decoder: RTL

- Receive-side counterpart of the multiplexed 8-digit 7-segment driver.
- Samples the anode/segment bus (an, duan, duan1) on the scan clock and decodes segment patterns back into digit codes and decimal points.
- Reassembles complete 4-slot scan frames and hands each one to a consumer through a one-deep valid/ready buffer.
- Used for on-chip self-check of the display path and as the bench monitor for the display path.

---
 rtl/display_capture_decoder.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/display_capture_decoder.sv
// display_capture_decoder: samples the multiplexed 8-digit 7-segment bus,
// decodes segment patterns to digit codes, reassembles 4-slot scan frames
// and hands them to a consumer through a one-deep valid/ready buffer.
module display_capture_decoder #(
    parameter int unsigned BLANK_LIMIT = 4
) (
    input  logic        clk_scan,
    input  logic        rst,
    input  logic [7:0]  an,
    input  logic [7:0]  duan,
    input  logic [7:0]  duan1,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [31:0] frame_digits,
    output logic [7:0]  frame_dp,
    output logic        frame_changed,
    output logic        seq_err,
    output logic        overrun,
    output logic        blanked
);

    localparam int unsigned DIG_W = 32;
    localparam int unsigned DP_W  = 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ASM1 = 2'd1,
        ASM2 = 2'd2,
        ASM3 = 2'd3
    } state_t;

    // Segment pattern (a..g) to digit code; unknown patterns map to 0xF.
    function automatic logic [3:0] seg_to_code(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'h7E:   code = 4'h0;
            7'h30:   code = 4'h1;
            7'h6D:   code = 4'h2;
            7'h79:   code = 4'h3;
            7'h33:   code = 4'h4;
            7'h5B:   code = 4'h5;
            7'h5F:   code = 4'h6;
            7'h70:   code = 4'h7;
            7'h7F:   code = 4'h8;
            7'h7B:   code = 4'h9;
            7'h0E:   code = 4'hA;
            7'h01:   code = 4'hB;
            7'h00:   code = 4'hC;
            default: code = 4'hF;
        endcase
        return code;
    endfunction

    state_t             state_q, state_d;
    logic [DIG_W-1:0]   cap_digits_q, cap_digits_d;
    logic [DP_W-1:0]    cap_dp_q, cap_dp_d;
    logic               frame_valid_q, frame_valid_d;
    logic [DIG_W-1:0]   frame_digits_q, frame_digits_d;
    logic [DP_W-1:0]    frame_dp_q, frame_dp_d;
    logic               frame_changed_q, frame_changed_d;
    logic               seq_err_q, seq_err_d;
    logic               overrun_q, overrun_d;
    logic               blanked_q, blanked_d;
    logic [CNT_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic [DIG_W-1:0]   ref_digits_q, ref_digits_d;
    logic [DP_W-1:0]    ref_dp_q, ref_dp_d;
    logic               ref_valid_q, ref_valid_d;

    logic               is_slot, is_dark, is_illegal;
    logic [1:0]         slot_idx;
    logic               capture, complete, accept;

    // Classify the anode pattern of the current sample.
    always_comb begin
        is_slot    = 1'b1;
        is_dark    = 1'b0;
        is_illegal = 1'b0;
        slot_idx   = 2'd0;
        case (an)
            8'b0001_0001: slot_idx = 2'd0;
            8'b0010_0010: slot_idx = 2'd1;
            8'b0100_0100: slot_idx = 2'd2;
            8'b1000_1000: slot_idx = 2'd3;
            8'b0000_0000: begin
                is_slot = 1'b0;
                is_dark = 1'b1;
            end
            default: begin
                is_slot    = 1'b0;
                is_illegal = 1'b1;
            end
        endcase
    end

    // Frame assembly FSM: next state, capture strobes and protocol errors.
    always_comb begin
        state_d   = state_q;
        seq_err_d = 1'b0;
        capture   = 1'b0;
        complete  = 1'b0;
        if (is_illegal) begin
            seq_err_d = 1'b1;
            state_d   = IDLE;
        end else if (is_dark) begin
            state_d = IDLE;
        end else if (is_slot) begin
            case (state_q)
                IDLE: begin
                    if (slot_idx == 2'd0) begin
                        capture = 1'b1;
                        state_d = ASM1;
                    end
                end
                default: begin
                    if (slot_idx == 2'(state_q)) begin
                        capture = 1'b1;
                        case (state_q)
                            ASM1:    state_d = ASM2;
                            ASM2:    state_d = ASM3;
                            default: begin
                                state_d  = IDLE;
                                complete = 1'b1;
                            end
                        endcase
                    end else begin
                        seq_err_d = 1'b1;
                        if (slot_idx == 2'd0) begin
                            capture = 1'b1;
                            state_d = ASM1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Merge the decoded slot pair into the partial frame.
    always_comb begin
        cap_digits_d = cap_digits_q;
        cap_dp_d     = cap_dp_q;
        if (capture) begin
            cap_digits_d[{1'b0, slot_idx, 2'b00} +: 4] = seg_to_code(duan[6:0]);
            cap_digits_d[{1'b1, slot_idx, 2'b00} +: 4] = seg_to_code(duan1[6:0]);
            cap_dp_d[{1'b0, slot_idx}]                 = duan[7];
            cap_dp_d[{1'b1, slot_idx}]                 = duan1[7];
        end
    end

    // Output buffer, delivered-frame reference and blank detection.
    always_comb begin
        logic [DIG_W-1:0] ref_digits_eff;
        logic [DP_W-1:0]  ref_dp_eff;
        logic             ref_valid_eff;

        accept          = frame_valid_q & frame_ready;
        frame_valid_d   = frame_valid_q;
        frame_digits_d  = frame_digits_q;
        frame_dp_d      = frame_dp_q;
        frame_changed_d = frame_changed_q;
        overrun_d       = overrun_q;
        ref_digits_d    = ref_digits_q;
        ref_dp_d        = ref_dp_q;
        ref_valid_d     = ref_valid_q;

        // A frame consumed on this edge is the reference for one loaded on it.
        if (accept) begin
            ref_digits_d = frame_digits_q;
            ref_dp_d     = frame_dp_q;
            ref_valid_d  = 1'b1;
        end
        ref_digits_eff = ref_digits_d;
        ref_dp_eff     = ref_dp_d;
        ref_valid_eff  = ref_valid_d;

        if (complete) begin
            frame_valid_d   = 1'b1;
            frame_digits_d  = cap_digits_d;
            frame_dp_d      = cap_dp_d;
            frame_changed_d = !ref_valid_eff ||
                              ({cap_digits_d, cap_dp_d} != {ref_digits_eff, ref_dp_eff});
            if (frame_valid_q && !frame_ready) begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            frame_valid_d = 1'b0;
        end

        if (is_dark) begin
            blank_cnt_d = (blank_cnt_q == {CNT_W{1'b1}}) ? blank_cnt_q : blank_cnt_q + CNT_W'(1);
            blanked_d   = (blank_cnt_d >= CNT_W'(BLANK_LIMIT));
        end else begin
            blank_cnt_d = '0;
            blanked_d   = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_scan or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cap_digits_q    <= '0;
            cap_dp_q        <= '0;
            frame_valid_q   <= 1'b0;
            frame_digits_q  <= '0;
            frame_dp_q      <= '0;
            frame_changed_q <= 1'b0;
            seq_err_q       <= 1'b0;
            overrun_q       <= 1'b0;
            blanked_q       <= 1'b0;
            blank_cnt_q     <= '0;
            ref_digits_q    <= '0;
            ref_dp_q        <= '0;
            ref_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cap_digits_q    <= cap_digits_d;
            cap_dp_q        <= cap_dp_d;
            frame_valid_q   <= frame_valid_d;
            frame_digits_q  <= frame_digits_d;
            frame_dp_q      <= frame_dp_d;
            frame_changed_q <= frame_changed_d;
            seq_err_q       <= seq_err_d;
            overrun_q       <= overrun_d;
            blanked_q       <= blanked_d;
            blank_cnt_q     <= blank_cnt_d;
            ref_digits_q    <= ref_digits_d;
            ref_dp_q        <= ref_dp_d;
            ref_valid_q     <= ref_valid_d;
        end
    end

    assign frame_valid   = frame_valid_q;
    assign frame_digits  = frame_digits_q;
    assign frame_dp      = frame_dp_q;
    assign frame_changed = frame_changed_q;
    assign seq_err       = seq_err_q;
    assign overrun       = overrun_q;
    assign blanked       = blanked_q;

endmodule
